spi_master_gen: RTL

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

---
 rtl/spi_master_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// SPI master with configurable word width, SCLK rate, SPI mode, bit order and
// chip-select count. Supports multi-word bursts that hold CS low between words.
module spi_master_gen #(
  parameter int DATA_W            = 16,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int SPI_MODE          = 0,
  parameter int LSB_FIRST         = 0,
  parameter int NUM_CS            = 1,
  localparam int CSW              = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [DATA_W-1:0] i_TX_Word,
  input  logic              i_Last,
  input  logic [CSW-1:0]    i_CS_Sel,
  output logic              o_TX_Ready,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Word,
  output logic              o_Busy,
  output logic              o_SPI_Clk,
  output logic              o_SPI_MOSI,
  input  logic              i_SPI_MISO,
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  localparam logic CPOL = ((SPI_MODE & 2) != 0);
  localparam logic CPHA = ((SPI_MODE & 1) != 0);
  localparam int CNT_W  = $clog2(CLKS_PER_HALF_BIT);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [CSW:0]      NUM_CS_L  = (CSW + 1)'(NUM_CS);

  typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StWaitNext, StCsHold} state_e;

  state_e              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic [DATA_W-1:0]   r_tx_sr, r_rx_sr, r_rx_word;
  logic                r_mosi, r_sclk, r_rx_dv, r_last;
  logic [NUM_CS-1:0]   r_cs_n, w_cs_dec_n;
  logic                w_ready, w_accept, w_cnt_max, w_edge, w_done, w_sample;
  logic                w_tx_first, w_word_first;
  logic [DATA_W-1:0]   w_tx_next, w_word_next, w_rx_next;

  // Handshake, SCLK edge timing and bit-order helpers
  always_comb begin
    w_ready   = (r_state == StIdle) || (r_state == StWaitNext);
    w_accept  = i_Start && w_ready &&
                ((r_state == StWaitNext) || ({1'b0, i_CS_Sel} < NUM_CS_L));
    w_cnt_max = (r_cnt == CNT_MAX);
    // CS_SETUP exit produces the first edge; SHIFT produces the remaining ones
    w_edge    = w_cnt_max && ((r_state == StCsSetup) ||
                              ((r_state == StShift) && (r_edge_cnt != EDGE_LAST)));
    // One half-bit after the final edge the received word is complete
    w_done    = w_cnt_max && (r_state == StShift) && (r_edge_cnt == EDGE_LAST);
    // Even count before the edge means a leading edge
    w_sample  = w_edge && (r_edge_cnt[0] == CPHA);
    for (int i = 0; i < NUM_CS; i++) begin
      w_cs_dec_n[i] = !(CSW'(i) == i_CS_Sel);
    end
    if (LSB_FIRST != 0) begin
      w_tx_first   = r_tx_sr[0];
      w_tx_next    = r_tx_sr >> 1;
      w_word_first = i_TX_Word[0];
      w_word_next  = i_TX_Word >> 1;
      w_rx_next    = {i_SPI_MISO, r_rx_sr[DATA_W-1:1]};
    end else begin
      w_tx_first   = r_tx_sr[DATA_W-1];
      w_tx_next    = r_tx_sr << 1;
      w_word_first = i_TX_Word[DATA_W-1];
      w_word_next  = i_TX_Word << 1;
      w_rx_next    = {r_rx_sr[DATA_W-2:0], i_SPI_MISO};
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_accept) w_state_next = StCsSetup;
      StCsSetup:  if (w_cnt_max) w_state_next = StShift;
      StShift:    if (r_rx_dv) w_state_next = r_last ? StCsHold : StWaitNext;
      StWaitNext: if (w_accept) w_state_next = StShift;
      StCsHold:   if (w_cnt_max) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // State register, half-bit counter, shift registers and CS/SCLK drivers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_word  <= '0;
      r_mosi     <= 1'b0;
      r_sclk     <= CPOL;
      r_rx_dv    <= 1'b0;
      r_last     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_state <= w_state_next;
      r_rx_dv <= w_done;
      // A burst word enters SHIFT one cycle into its first half-bit, which keeps
      // the accept-to-RX_DV latency equal to 2*DATA_W+1 half-bits
      if (w_accept && (r_state == StWaitNext)) begin
        r_cnt <= CNT_W'(1);
      end else if ((w_state_next != r_state) || (r_state == StIdle) ||
                   (r_state == StWaitNext) || w_cnt_max) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_last     <= i_Last;
        r_edge_cnt <= '0;
        if (r_state == StIdle) r_cs_n <= w_cs_dec_n;
        if (!CPHA) begin
          r_mosi  <= w_word_first;
          r_tx_sr <= w_word_next;
        end else begin
          r_tx_sr <= i_TX_Word;
        end
      end
      if (w_edge) begin
        r_sclk     <= ~r_sclk;
        r_edge_cnt <= r_edge_cnt + 1'b1;
        if (w_sample) begin
          r_rx_sr <= w_rx_next;
        end else begin
          r_mosi  <= w_tx_first;
          r_tx_sr <= w_tx_next;
        end
      end
      if (w_done) r_rx_word <= r_rx_sr;
      if ((r_state == StCsHold) && w_cnt_max) r_cs_n <= '1;
    end
  end

  assign o_TX_Ready = w_ready;
  assign o_Busy     = (r_state != StIdle);
  assign o_RX_DV    = r_rx_dv;
  assign o_RX_Word  = r_rx_word;
  assign o_SPI_Clk  = r_sclk;
  assign o_SPI_MOSI = r_mosi;
  assign o_SPI_CS_n = r_cs_n;

endmodule
